// File: rtl/keysearch_stage_sequencer.sv
// rtl/keysearch_stage_sequencer.sv - main controller for the RC4 key-search datapath
// Runs the sub-blocks in order for each candidate key and steps the key until a verdict.
module keysearch_stage_sequencer #(
  parameter int unsigned          NUM_STAGES     = 3,
  parameter int unsigned          KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST       = KEY_WIDTH'(24'h3FFFFF),
  parameter int unsigned          TIMEOUT_CYCLES = 0,
  parameter int unsigned          SEL_WIDTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_STAGES-1:0] stage_finish_i,
  input  logic                  key_ok_i,
  output logic [NUM_STAGES-1:0] stage_start_o,
  output logic [SEL_WIDTH-1:0]  select_share_o,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic                  busy_o,
  output logic                  found_o,
  output logic                  exhausted_o,
  output logic                  timeout_err_o
);

  localparam int unsigned          CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST   = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SEL_WIDTH-1:0] IDX_LAST   = SEL_WIDTH'(NUM_STAGES - 1);
  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  if (KEY_LAST < KEY_START) begin : g_bad_key_range
    $error("KEY_LAST must not be below KEY_START");
  end
  if (NUM_STAGES < 1) begin : g_bad_num_stages
    $error("NUM_STAGES must be at least 1");
  end
  if ((2 ** SEL_WIDTH) < NUM_STAGES) begin : g_bad_sel_width
    $error("SEL_WIDTH too narrow for NUM_STAGES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_FOUND,
    S_FAIL
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    idx_q, idx_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    found_q, found_d;
  logic                    exhausted_q, exhausted_d;
  logic                    timeout_q, timeout_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    busy_q, busy_d;
  logic                    finish_sel;

  // Only the finish bit of the stage currently owning the key is observed.
  always_comb begin
    finish_sel = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (idx_q == SEL_WIDTH'(i)) begin
        finish_sel = stage_finish_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE, S_FOUND, S_FAIL: begin
        if (start_i) begin
          state_d     = S_LAUNCH;
          key_d       = KEY_START;
          idx_d       = '0;
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A finish arriving on the last allowed cycle still counts.
        if (finish_sel) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + SEL_WIDTH'(1);
            state_d = S_LAUNCH;
          end else begin
            state_d = S_CHECK;
          end
        end else if (TIMEOUT_EN) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = S_FAIL;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (key_ok_i) begin
          state_d = S_FOUND;
          found_d = 1'b1;
        end else if (key_q == KEY_LAST) begin
          state_d     = S_FAIL;
          exhausted_d = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        key_d   = key_q + KEY_WIDTH'(1);
        idx_d   = '0;
        state_d = S_LAUNCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      key_d       = KEY_START;
      cnt_d       = '0;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    stage_start_d = '0;
    busy_d        = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
                    (state_d == S_CHECK)  || (state_d == S_NEXT);
    sel_d         = busy_d ? idx_d : '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      stage_start_d[i] = (state_d == S_LAUNCH) && (idx_d == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      key_q         <= KEY_START;
      cnt_q         <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
      stage_start_q <= '0;
      sel_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      cnt_q         <= cnt_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      timeout_q     <= timeout_d;
      stage_start_q <= stage_start_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
    end
  end

  assign stage_start_o  = stage_start_q;
  assign select_share_o = sel_q;
  assign key_o          = key_q;
  assign busy_o         = busy_q;
  assign found_o        = found_q;
  assign exhausted_o    = exhausted_q;
  assign timeout_err_o  = timeout_q;

endmodule

// File: tb/tb_keysearch_stage_sequencer.sv
// tb/tb_keysearch_stage_sequencer.sv - bench for keysearch_stage_sequencer
// Builds an expected per-cycle timeline from stage latencies, then replays it on one of three DUTs.
module tb_keysearch_stage_sequencer;

  localparam int MAXT = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       st  [3];
  logic       ab  [3];
  logic       ok  [3];
  logic [2:0] fin [3];

  logic [2:0]  ss0, ss1;
  logic [0:0]  ss2;
  logic [1:0]  sel0, sel1;
  logic [0:0]  sel2;
  logic [23:0] key0, key1, key2;
  logic        busy0, busy1, busy2;
  logic        fnd0, fnd1, fnd2;
  logic        exh0, exh1, exh2;
  logic        to0, to1, to2;

  keysearch_stage_sequencer u_dut0 (
    .clk_i(clk), .reset_i(rst[0]), .start_i(st[0]), .abort_i(ab[0]),
    .stage_finish_i(fin[0]), .key_ok_i(ok[0]),
    .stage_start_o(ss0), .select_share_o(sel0), .key_o(key0), .busy_o(busy0),
    .found_o(fnd0), .exhausted_o(exh0), .timeout_err_o(to0)
  );

  keysearch_stage_sequencer #(.KEY_LAST(24'd3), .TIMEOUT_CYCLES(8)) u_dut1 (
    .clk_i(clk), .reset_i(rst[1]), .start_i(st[1]), .abort_i(ab[1]),
    .stage_finish_i(fin[1]), .key_ok_i(ok[1]),
    .stage_start_o(ss1), .select_share_o(sel1), .key_o(key1), .busy_o(busy1),
    .found_o(fnd1), .exhausted_o(exh1), .timeout_err_o(to1)
  );

  keysearch_stage_sequencer #(.NUM_STAGES(1), .SEL_WIDTH(1), .KEY_LAST(24'd7)) u_dut2 (
    .clk_i(clk), .reset_i(rst[2]), .start_i(st[2]), .abort_i(ab[2]),
    .stage_finish_i(fin[2][0:0]), .key_ok_i(ok[2]),
    .stage_start_o(ss2), .select_share_o(sel2), .key_o(key2), .busy_o(busy2),
    .found_o(fnd2), .exhausted_o(exh2), .timeout_err_o(to2)
  );

  int nst   [3] = '{3, 3, 1};
  int klast [3] = '{32'h3FFFFF, 3, 7};
  int tmo   [3] = '{0, 8, 0};

  logic [31:0] e_ss [MAXT];
  logic [31:0] e_sel [MAXT];
  logic [31:0] e_busy [MAXT];
  logic [31:0] e_key [MAXT];
  logic [31:0] e_flg [MAXT];
  bit          dc_sel [MAXT];
  logic [2:0]  d_fin [MAXT];
  logic [2:0]  prot [MAXT];
  logic        d_ok [MAXT];
  bit          okfix [MAXT];
  logic        d_ab [MAXT];
  logic        d_rst [MAXT];

  int e_end;
  int ncyc;
  int noise;
  int n_vec;
  int n_mis;

  task automatic put(input int t, input int ss, input int sel, input bit dcs,
                     input int busy, input int key, input int flg);
    if (t < MAXT) begin
      e_ss[t]   = ss;
      e_sel[t]  = sel;
      dc_sel[t] = dcs;
      e_busy[t] = busy;
      e_key[t]  = key;
      e_flg[t]  = flg;
    end
  endtask

  task automatic final_state(input int t0, input int key, input int flg);
    e_end = t0;
    for (int i = 0; i < 4; i++) put(t0 + i, 0, 0, 0, 0, key, flg);
    ncyc = t0 + 4;
  endtask

  // Flags encoding: bit0 found, bit1 exhausted, bit2 timeout.
  // amode: 0 none, 1 abort with the last-stage finish of key 0, 2 abort at a random busy
  // cycle, 3 reset at a random busy cycle, 4 abort together with start.
  task automatic build(input int u, input int match, input int fixlat,
                       input int hang_s, input int hang_k, input int amode);
    int  t, k, s, lat, last_fin, ta;
    bit  done;
    for (int i = 0; i < MAXT; i++) begin
      put(i, 0, 0, 0, 0, 0, 0);
      d_fin[i] = '0; prot[i] = '0; d_ok[i] = 1'b0; okfix[i] = 1'b0;
      d_ab[i] = 1'b0; d_rst[i] = 1'b0;
    end
    t = 1; k = 0; done = 1'b0; last_fin = 1;
    while (!done) begin
      for (s = 0; s < nst[u] && !done; s++) begin
        put(t, 1 << s, s, 0, 1, k, 0);
        if (s > 0 && noise == 2) d_fin[t][s-1] = 1'b1;
        if (k == hang_k && s == hang_s) lat = 1000;
        else if (fixlat > 0) lat = fixlat;
        else lat = $urandom_range(1, (tmo[u] != 0) ? tmo[u] : 6);
        if (tmo[u] != 0 && lat > tmo[u]) begin
          for (int w = 1; w <= tmo[u]; w++) begin
            put(t + w, 0, s, 0, 1, k, 0);
            prot[t+w][s] = 1'b1;
          end
          final_state(t + tmo[u] + 1, k, 4);
          done = 1'b1;
        end else begin
          for (int w = 1; w <= lat; w++) begin
            put(t + w, 0, s, 0, 1, k, 0);
            prot[t+w][s] = 1'b1;
            if (noise == 2 && s == 0 && nst[u] > 2) d_fin[t+w][2] = 1'b1;
          end
          d_fin[t+lat][s] = 1'b1;
          if (s == nst[u] - 1 && k == 0) last_fin = t + lat;
          t = t + lat + 1;
        end
      end
      if (!done) begin
        put(t, 0, 0, 1, 1, k, 0);
        okfix[t] = 1'b1;
        d_ok[t]  = (k == match);
        if (k == match) begin
          final_state(t + 1, k, 1);
          done = 1'b1;
        end else if (k == klast[u]) begin
          final_state(t + 1, k, 2);
          done = 1'b1;
        end else begin
          put(t + 1, 0, 0, 1, 1, k, 0);
          t = t + 2;
          k++;
        end
      end
    end
    if (amode != 0) begin
      case (amode)
        1:       ta = last_fin;
        4:       ta = 0;
        default: ta = $urandom_range(1, e_end - 1);
      endcase
      d_ab[ta] = (amode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      d_rst[ta] = (amode == 3);
      for (int i = 1; i <= 4; i++) put(ta + i, 0, 0, 0, 0, 0, 0);
      e_end = ta + 1;
      ncyc  = ta + 5;
    end
  endtask

  task automatic chk(input string tag, input int u, input int t,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s dut%0d cycle%0d: observed=%0h expected=%0h", tag, u, t, obs, exp);
    end
  endtask

  task automatic check(input int u, input int t);
    logic [31:0] o_ss, o_sel, o_busy, o_key, o_flg;
    case (u)
      0: begin
        o_ss = 32'(ss0); o_sel = 32'(sel0); o_busy = 32'(busy0);
        o_key = 32'(key0); o_flg = 32'({to0, exh0, fnd0});
      end
      1: begin
        o_ss = 32'(ss1); o_sel = 32'(sel1); o_busy = 32'(busy1);
        o_key = 32'(key1); o_flg = 32'({to1, exh1, fnd1});
      end
      default: begin
        o_ss = 32'(ss2); o_sel = 32'(sel2); o_busy = 32'(busy2);
        o_key = 32'(key2); o_flg = 32'({to2, exh2, fnd2});
      end
    endcase
    chk("stage_start", u, t, o_ss, e_ss[t]);
    if (!dc_sel[t]) chk("select_share", u, t, o_sel, e_sel[t]);
    chk("busy", u, t, o_busy, e_busy[t]);
    chk("key", u, t, o_key, e_key[t]);
    chk("flags", u, t, o_flg, e_flg[t]);
  endtask

  task automatic run(input int u);
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      st[u]  = (t == 0) ? 1'b1 : ((t < e_end) ? 1'($urandom_range(0, 1)) : 1'b0);
      ab[u]  = d_ab[t];
      rst[u] = d_rst[t];
      ok[u]  = okfix[t] ? d_ok[t] : 1'($urandom_range(0, 1));
      fin[u] = ((noise != 0) ? (3'($urandom) & ~prot[t]) : 3'b000) | d_fin[t];
      @(negedge clk);
      if (t >= 1) check(u, t);
    end
    @(posedge clk);
    #1;
    st[u] = 1'b0; ab[u] = 1'b0; rst[u] = 1'b0; ok[u] = 1'b0; fin[u] = '0;
  endtask

  initial begin
    int u, m, r, am, hs, hk;
    n_vec = 0;
    n_mis = 0;
    noise = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; ab[i] = 1'b0; ok[i] = 1'b0; fin[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) check(i, 0);

    noise = 0; build(0, 0, 3, -1, -1, 0);  run(0);
    noise = 1; build(1, -1, 0, -1, -1, 0); run(1);
    build(1, -1, 0, 1, 0, 0);              run(1);
    build(0, 5, 0, -1, -1, 1);             run(0);
    noise = 2; build(0, 1, 0, -1, -1, 0);  run(0);
    noise = 1; build(2, 2, 0, -1, -1, 0);  run(2);
    build(2, 0, 0, -1, -1, 0);             run(2);
    build(2, -1, 0, -1, -1, 0);            run(2);
    build(1, 2, 8, -1, -1, 0);             run(1);
    build(0, 0, 0, -1, -1, 4);             run(0);

    for (int n = 0; n < 30; n++) begin
      u = $urandom_range(0, 2);
      noise = $urandom_range(1, 2);
      case (u)
        0:       m = $urandom_range(0, 3);
        1:       m = int'($urandom_range(0, 4)) - 1;
        default: m = int'($urandom_range(0, 8)) - 1;
      endcase
      r  = $urandom_range(0, 9);
      am = (r < 6) ? 0 : (r < 8) ? 2 : (r < 9) ? 3 : 4;
      hs = -1; hk = -1;
      if (u == 1 && $urandom_range(0, 3) == 0) begin
        hs = $urandom_range(0, 2);
        hk = $urandom_range(0, 3);
      end
      build(u, m, 0, hs, hk, am);
      run(u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
